// File: rtl/uart_bus_bridge.sv
// CPU register-bus front end for a UART transmitter/receiver pair.
// Holds a TX FIFO feeding a start/busy handshake and an RX FIFO with a sticky overrun flag.
module uart_bus_bridge #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_ce,
    input  logic        bus_we,
    input  logic        bus_addr,
    input  logic [7:0]  bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_ack,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    output logic        irq
);

    localparam logic [1:0] T_IDLE  = 2'd0;
    localparam logic [1:0] T_START = 2'd1;
    localparam logic [1:0] T_HOLD  = 2'd2;

    localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

    logic [7:0]    txMem [DEPTH];
    logic [7:0]    rxMem [DEPTH];
    logic [AW-1:0] txWr, txRd, rxWr, rxRd;
    logic [AW:0]   txCount, rxCount;
    logic          rxOvr;
    logic [1:0]    txState;

    logic        txFull, txEmpty, rxFull, rxNempty;
    logic        rxPop, rxPush, rxOvrSet, statRd, txPush, txPop;
    logic [31:0] rdataNext;

    always_comb begin
        txFull   = (txCount == FullCount);
        txEmpty  = (txCount == '0);
        rxFull   = (rxCount == FullCount);
        rxNempty = (rxCount != '0);
        rxPop    = bus_ce && !bus_we && !bus_addr && rxNempty;
        // A pop in the same cycle frees the slot, so a full RX FIFO still accepts the byte.
        rxPush   = rx_ready && (!rxFull || rxPop);
        rxOvrSet = rx_ready && rxFull && !rxPop;
        statRd   = bus_ce && !bus_we && bus_addr;
        txPush   = bus_ce && bus_we && !bus_addr && !txFull;
        txPop    = (txState == T_IDLE) && !txEmpty && !tx_busy;
        rdataNext = '0;
        if (statRd) begin
            rdataNext[3:0] = {rxOvr, rxNempty, txEmpty, txFull};
        end else if (rxPop) begin
            rdataNext[7:0] = rxMem[rxRd];
        end
    end

    always_ff @(posedge clk) begin
        if (txPush) begin
            txMem[txWr] <= bus_wdata;
        end
        if (rxPush) begin
            rxMem[rxWr] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_ack   <= 1'b0;
            bus_rdata <= '0;
            txWr      <= '0;
            txRd      <= '0;
            txCount   <= '0;
            rxWr      <= '0;
            rxRd      <= '0;
            rxCount   <= '0;
            rxOvr     <= 1'b0;
            txState   <= T_IDLE;
            tx_start  <= 1'b0;
            tx_data   <= '0;
            irq       <= 1'b0;
        end else begin
            bus_ack   <= bus_ce;
            bus_rdata <= bus_ce ? rdataNext : '0;

            if (txPush) begin
                txWr <= txWr + AW'(1);
            end
            if (txPop) begin
                txRd <= txRd + AW'(1);
            end
            txCount <= txCount + (AW+1)'(txPush) - (AW+1)'(txPop);

            if (rxPush) begin
                rxWr <= rxWr + AW'(1);
            end
            if (rxPop) begin
                rxRd <= rxRd + AW'(1);
            end
            rxCount <= rxCount + (AW+1)'(rxPush) - (AW+1)'(rxPop);

            if (rxOvrSet) begin
                rxOvr <= 1'b1;
            end else if (statRd) begin
                rxOvr <= 1'b0;
            end

            irq <= rxNempty | rxOvr;

            // T_START gives the transmitter one cycle to raise busy before it is watched.
            case (txState)
                T_IDLE: begin
                    if (txPop) begin
                        tx_data  <= txMem[txRd];
                        tx_start <= 1'b1;
                        txState  <= T_START;
                    end
                end
                T_START: begin
                    tx_start <= 1'b0;
                    txState  <= T_HOLD;
                end
                T_HOLD: begin
                    if (!tx_busy) begin
                        txState <= T_IDLE;
                    end
                end
                default: begin
                    tx_start <= 1'b0;
                    txState  <= T_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed bench for uart_bus_bridge with a simple transmitter model.
module tb_uart_bus_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_ce, bus_we, bus_addr;
    logic [7:0]  bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        irq;

    int          vectors = 0;
    int          miscompares = 0;
    logic        forceBusy = 1'b0;
    logic        prevStart = 1'b0;
    int          busyCnt = 0;
    logic [7:0]  txLog [$];

    always #5 clk = ~clk;

    assign tx_busy = forceBusy || (busyCnt != 0);

    uart_bus_bridge dut (
        .clk       (clk),
        .rst       (rst),
        .bus_ce    (bus_ce),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .irq       (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Transmitter model: busy for 10 cycles after each start pulse.
    always @(negedge clk) begin
        if (tx_start) begin
            txLog.push_back(tx_data);
            check("start_not_back_to_back", {31'b0, prevStart}, 32'h0);
        end
        prevStart <= tx_start;
        if (tx_start) begin
            busyCnt <= 10;
        end else if (busyCnt != 0) begin
            busyCnt <= busyCnt - 1;
        end
    end

    task automatic busAccess(input logic we, input logic addr, input logic [7:0] wd,
                             output logic [31:0] rd);
        bus_ce    = 1'b1;
        bus_we    = we;
        bus_addr  = addr;
        bus_wdata = wd;
        @(negedge clk);
        bus_ce    = 1'b0;
        bus_we    = 1'b0;
        check("ack", {31'b0, bus_ack}, 32'h1);
        rd = bus_rdata;
    endtask

    task automatic readExpect(input string tag, input logic addr, input logic [31:0] exp);
        logic [31:0] rd;
        busAccess(1'b0, addr, 8'h00, rd);
        check(tag, rd, exp);
    endtask

    task automatic writeByte(input logic addr, input logic [7:0] wd);
        logic [31:0] rd;
        busAccess(1'b1, addr, wd, rd);
    endtask

    task automatic rxPulse(input logic [7:0] v);
        rx_ready = 1'b1;
        rx_data  = v;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic waitLog(input string tag, input int want, input int budget);
        for (int i = 0; i < budget && txLog.size() < want; i++) @(negedge clk);
        check(tag, txLog.size(), want);
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 100 && tx_busy; i++) @(negedge clk);
        check("tx_idle", {31'b0, tx_busy}, 32'h0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [31:0] rd;
        rst = 1'b1; bus_ce = 1'b0; bus_we = 1'b0; bus_addr = 1'b0; bus_wdata = '0;
        rx_ready = 1'b0; rx_data = '0;
        repeat (3) @(negedge clk);
        check("rst_ack", {31'b0, bus_ack}, 32'h0);
        check("rst_rdata", bus_rdata, 32'h0);
        check("rst_tx_start", {31'b0, tx_start}, 32'h0);
        check("rst_tx_data", {24'b0, tx_data}, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // 1: STATUS after reset = tx_empty only
        readExpect("status_reset", 1'b1, 32'h2);
        @(negedge clk);
        check("ack_one_cycle", {31'b0, bus_ack}, 32'h0);
        check("irq_idle", {31'b0, irq}, 32'h0);
        writeByte(1'b1, 8'hFF);
        readExpect("status_write_ignored", 1'b1, 32'h2);

        // 2: two bytes through the transmitter model
        writeByte(1'b0, 8'h41);
        writeByte(1'b0, 8'h42);
        waitLog("tx2_count", 2, 200);
        check("tx2_byte0", {24'b0, txLog[0]}, 32'h41);
        check("tx2_byte1", {24'b0, txLog[1]}, 32'h42);
        readExpect("status_after_tx2", 1'b1, 32'h2);
        waitIdle();

        // 3: 17 writes with busy held, the 17th is dropped
        forceBusy = 1'b1;
        base = txLog.size();
        for (int i = 0; i < 16; i++) writeByte(1'b0, 8'(i));
        readExpect("status_tx_full", 1'b1, 32'h1);
        writeByte(1'b0, 8'h10);
        readExpect("status_tx_still_full", 1'b1, 32'h1);
        check("tx_held_no_start", txLog.size(), base);
        forceBusy = 1'b0;
        waitLog("tx16_count", base + 16, 1000);
        repeat (40) @(negedge clk);
        check("tx16_extra_dropped", txLog.size(), base + 16);
        for (int i = 0; i < 16; i++) begin
            if (base + i < txLog.size()) check("tx16_order", {24'b0, txLog[base+i]}, i);
        end
        readExpect("status_tx_drained", 1'b1, 32'h2);
        waitIdle();

        // 4: two RX bytes, then read past empty
        rxPulse(8'h55);
        rxPulse(8'hAA);
        repeat (2) @(negedge clk);
        check("irq_rx", {31'b0, irq}, 32'h1);
        readExpect("rx_read0", 1'b0, 32'h55);
        readExpect("rx_read1", 1'b0, 32'hAA);
        readExpect("rx_read_empty", 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        check("irq_cleared", {31'b0, irq}, 32'h0);

        // 5: overrun; tx_empty stays set, so ovr|nempty|tx_empty = 0xE
        for (int i = 0; i < 17; i++) rxPulse(8'h20 + 8'(i));
        repeat (2) @(negedge clk);
        check("irq_ovr", {31'b0, irq}, 32'h1);
        readExpect("status_ovr", 1'b1, 32'hE);
        readExpect("status_ovr_cleared", 1'b1, 32'h6);
        for (int i = 0; i < 16; i++) readExpect("rx_ovr_drain", 1'b0, 32'h20 + i);
        readExpect("rx_ovr_empty", 1'b0, 32'h0);

        // 6: full RX with simultaneous push and pop
        for (int i = 0; i < 16; i++) rxPulse(8'h60 + 8'(i));
        rx_ready = 1'b1;
        rx_data  = 8'h99;
        busAccess(1'b0, 1'b0, 8'h00, rd);
        rx_ready = 1'b0;
        check("rx_pushpop_oldest", rd, 32'h60);
        readExpect("status_no_ovr", 1'b1, 32'h6);
        for (int i = 1; i < 16; i++) readExpect("rx_full_drain", 1'b0, 32'h60 + i);
        readExpect("rx_last_entry", 1'b0, 32'h99);
        readExpect("rx_full_empty", 1'b0, 32'h0);
        readExpect("status_rx_drained", 1'b1, 32'h2);

        // Reset during a transfer drops queued TX and RX bytes
        base = txLog.size();
        writeByte(1'b0, 8'hA1);
        writeByte(1'b0, 8'hA2);
        writeByte(1'b0, 8'hA3);
        waitLog("midtx_first", base + 1, 50);
        rxPulse(8'h11);
        rxPulse(8'h22);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_tx_start", {31'b0, tx_start}, 32'h0);
        check("midrst_tx_data", {24'b0, tx_data}, 32'h0);
        check("midrst_irq", {31'b0, irq}, 32'h0);
        readExpect("status_midrst", 1'b1, 32'h2);
        repeat (40) @(negedge clk);
        check("midrst_no_more_tx", txLog.size(), base + 1);
        check("midrst_irq_later", {31'b0, irq}, 32'h0);
        readExpect("rx_midrst_empty", 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
